// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
package stopwatch_pkg;

  // Width of one BCD digit.
  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } sw_state_e;

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on the accepted released-to-pressed transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, count consecutive differing samples, accept after a full run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      press_q     <= level_dly_q & ~level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch: up/down counting, lap freeze, wrap pulse and done state.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DIGITS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    KEY_START,
  input  logic                    KEY_CLEAR,
  input  logic                    KEY_LAP,
  input  logic                    MODE_DOWN,
  input  logic [BCD_W*DIGITS-1:0] PRESET_BCD,
  output logic [BCD_W*DIGITS-1:0] BCD_OUT,
  output logic                    RUNNING,
  output logic                    LAP_ACTIVE,
  output logic                    WRAP,
  output logic                    DONE
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = BCD_W * DIGITS;

  logic start_press, clear_press, lap_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY_START), .press(start_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY_CLEAR), .press(clear_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY_LAP), .press(lap_press)
  );

  sw_state_e         state_q;
  logic [PW-1:0]     presc_q;
  logic [CW-1:0]     count_q, lap_q, bcd_out_q;
  logic              mode_q, lap_active_q, wrap_q, running_q, done_q;

  logic [CW-1:0]     count_inc, count_dec, preset_clean;
  logic [BCD_W-1:0]  digit;
  logic              carry, borrow, all_nines;
  logic              tick, reach_zero;

  // Digit-wise ripple increment/decrement; out-of-range preset digits clamp to 9.
  always_comb begin
    count_inc    = count_q;
    count_dec    = count_q;
    preset_clean = PRESET_BCD;
    carry        = 1'b1;
    borrow       = 1'b1;
    digit        = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = count_q[i*BCD_W +: BCD_W];
      if (carry) begin
        if (digit == 4'd9) begin
          count_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          count_inc[i*BCD_W +: BCD_W] = digit + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (digit == 4'd0) begin
          count_dec[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          count_dec[i*BCD_W +: BCD_W] = digit - 4'd1;
          borrow = 1'b0;
        end
      end
      if (PRESET_BCD[i*BCD_W +: BCD_W] > 4'd9) begin
        preset_clean[i*BCD_W +: BCD_W] = 4'd9;
      end
    end
    all_nines = carry;
  end

  assign tick       = (state_q == StRun) && (presc_q == PW'(DIV - 1));
  assign reach_zero = tick && mode_q && (count_dec == '0);

  // Control FSM with count, lap, prescaler and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      count_q      <= '0;
      lap_q        <= '0;
      bcd_out_q    <= '0;
      mode_q       <= 1'b0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wrap_q    <= 1'b0;
      bcd_out_q <= lap_active_q ? lap_q : count_q;

      if (state_q == StRun) presc_q <= tick ? '0 : presc_q + 1'b1;

      if (tick) begin
        if (mode_q) begin
          count_q <= count_dec;
          if (reach_zero) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end else begin
          count_q <= count_inc;
          wrap_q  <= all_nines;
        end
      end

      // Up mode keeps the held count, so a preset loaded in down mode can seed an up count.
      if (state_q == StIdle) begin
        mode_q <= MODE_DOWN;
        if (MODE_DOWN) count_q <= preset_clean;
      end

      if (lap_press && (state_q == StRun || state_q == StPause)) begin
        lap_active_q <= ~lap_active_q;
        if (!lap_active_q) lap_q <= count_q;
      end

      // Clear outranks start; a clear swallowed in RUN lets start through.
      if (clear_press && state_q != StRun) begin
        count_q      <= mode_q ? preset_clean : '0;
        lap_active_q <= 1'b0;
        presc_q      <= '0;
        state_q      <= StIdle;
        running_q    <= 1'b0;
        done_q       <= 1'b0;
      end else if (start_press) begin
        case (state_q)
          StIdle: begin
            if (mode_q && count_q == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          StRun: begin
            if (!reach_zero) begin
              state_q   <= StPause;
              running_q <= 1'b0;
            end
          end
          StPause: begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign BCD_OUT    = bcd_out_q;
  assign RUNNING    = running_q;
  assign LAP_ACTIVE = lap_active_q;
  assign WRAP       = wrap_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with a scoreboard of expected values.
module tb_stopwatch_bcd;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        KEY_START, KEY_CLEAR, KEY_LAP, MODE_DOWN;
  logic [15:0] PRESET_BCD;
  logic [15:0] BCD_OUT;
  logic        RUNNING, LAP_ACTIVE, WRAP, DONE;

  localparam logic [2:0] KStart = 3'b001;
  localparam logic [2:0] KClear = 3'b010;
  localparam logic [2:0] KLap   = 3'b100;

  stopwatch_bcd #(
    .CLK_HZ(100), .TICK_HZ(10), .DIGITS(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY_START(KEY_START), .KEY_CLEAR(KEY_CLEAR),
    .KEY_LAP(KEY_LAP), .MODE_DOWN(MODE_DOWN), .PRESET_BCD(PRESET_BCD), .BCD_OUT(BCD_OUT),
    .RUNNING(RUNNING), .LAP_ACTIVE(LAP_ACTIVE), .WRAP(WRAP), .DONE(DONE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int start_pulses = 0, clear_pulses = 0, lap_pulses = 0;
  int start_edge = -1;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always @(posedge CLOCK_50) edge_cnt++;

  // Press pulses are sampled mid-cycle, well away from the active edge.
  always @(negedge CLOCK_50) begin
    if (dut.u_start_db.press === 1'b1) begin
      start_pulses++;
      start_edge = edge_cnt;
    end
    if (dut.u_clear_db.press === 1'b1) clear_pulses++;
    if (dut.u_lap_db.press === 1'b1) lap_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    tag = "scoreboard_empty";
    exp = 'x;
    if (exp_q.size() != 0) begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
    end
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] m);
    if (m[0]) KEY_START = 1'b0;
    if (m[1]) KEY_CLEAR = 1'b0;
    if (m[2]) KEY_LAP = 1'b0;
    tick(8);
  endtask

  task automatic release_keys();
    KEY_START = 1'b1;
    KEY_CLEAR = 1'b1;
    KEY_LAP   = 1'b1;
    tick(8);
  endtask

  task automatic seed_up(input logic [15:0] v);
    MODE_DOWN  = 1'b1;
    PRESET_BCD = v;
    tick(2);
    MODE_DOWN  = 1'b0;
    PRESET_BCD = '0;
    tick(2);
  endtask

  int e0;
  int snap_pulses;

  initial begin
    RESET_N = 1'b0; KEY_START = 1'b1; KEY_CLEAR = 1'b1; KEY_LAP = 1'b1;
    MODE_DOWN = 1'b0; PRESET_BCD = '0;
    sb_push("rst_bcd", 0); sb_push("rst_run", 0); sb_push("rst_lap", 0);
    sb_push("rst_wrap", 0); sb_push("rst_done", 0);
    tick(3);
    pop_check(BCD_OUT); pop_check(RUNNING); pop_check(LAP_ACTIVE);
    pop_check(WRAP); pop_check(DONE);
    RESET_N = 1'b1;
    tick(2);

    // Held start key: one pulse at edge 7, one tick later the display shows 0001.
    e0 = edge_cnt;
    KEY_START = 1'b0;
    sb_push("a_running", 1); sb_push("a_bcd_pre", 16'h0000); sb_push("a_bcd_1", 16'h0001);
    tick(8);  pop_check(RUNNING);
    tick(10); pop_check(BCD_OUT);
    tick(1);  pop_check(BCD_OUT);
    tick(1);
    KEY_START = 1'b1;
    sb_push("a_pulses", 1); sb_push("a_pulse_edge", 7);
    tick(10);
    pop_check(start_pulses);
    pop_check(start_edge - e0);

    // Pause press coincides with the third tick; the tick still lands.
    sb_push("a_paused", 0); sb_push("a_bcd_3", 16'h0003);
    press(KStart); pop_check(RUNNING);
    release_keys(); pop_check(BCD_OUT);
    MODE_DOWN = 1'b1; PRESET_BCD = 16'h0777;
    sb_push("a_pause_hold", 16'h0003);
    tick(20); pop_check(BCD_OUT);
    MODE_DOWN = 1'b0; PRESET_BCD = '0;

    // Clear+start in PAUSE clears; in RUN only the start acts.
    sb_push("b_pause_run", 0); sb_push("b_pause_bcd", 16'h0000);
    press(KStart | KClear); pop_check(RUNNING);
    release_keys(); pop_check(BCD_OUT);
    sb_push("b_run", 1);
    press(KStart); pop_check(RUNNING);
    release_keys();
    sb_push("b_run_paused", 0); sb_push("b_run_bcd", 16'h0001);
    press(KStart | KClear); pop_check(RUNNING);
    release_keys(); pop_check(BCD_OUT);
    sb_push("b_clear_bcd", 16'h0000);
    press(KClear); release_keys(); pop_check(BCD_OUT);

    // Lap freeze at 0042 while the count runs on to 0045.
    seed_up(16'h0041);
    sb_push("c_seed", 16'h0041);
    pop_check(BCD_OUT);
    press(KStart); release_keys();
    sb_push("c_lap_on", 1);
    press(KLap); pop_check(LAP_ACTIVE);
    release_keys();
    sb_push("c_count_45", 16'h0045); sb_push("c_frozen", 16'h0042);
    tick(16);
    pop_check(dut.count_q); pop_check(BCD_OUT);
    sb_push("c_lap_off", 0); sb_push("c_live", 16'h0045);
    press(KLap); pop_check(LAP_ACTIVE);
    tick(1); pop_check(BCD_OUT);
    release_keys();
    press(KStart); release_keys();
    sb_push("c_cleared", 16'h0000);
    press(KClear); release_keys(); pop_check(BCD_OUT);

    // Up-count rollover from 9999.
    seed_up(16'h9999);
    sb_push("d_seed", 16'h9999);
    pop_check(BCD_OUT);
    press(KStart); release_keys();
    sb_push("d_wrap_pre", 0); sb_push("d_bcd_pre", 16'h9999);
    tick(1); pop_check(WRAP); pop_check(BCD_OUT);
    sb_push("d_wrap", 1);
    tick(1); pop_check(WRAP);
    sb_push("d_wrap_post", 0); sb_push("d_bcd_wrapped", 16'h0000); sb_push("d_running", 1);
    tick(1); pop_check(WRAP); pop_check(BCD_OUT); pop_check(RUNNING);
    press(KStart); release_keys();
    press(KClear); release_keys();

    // Down count from 0003 to DONE.
    MODE_DOWN = 1'b1; PRESET_BCD = 16'h0003;
    sb_push("e_preset", 16'h0003);
    tick(2); pop_check(BCD_OUT);
    press(KStart); release_keys();
    sb_push("e_bcd_1", 16'h0001); sb_push("e_done_pre", 0);
    tick(21); pop_check(BCD_OUT); pop_check(DONE);
    sb_push("e_done", 1); sb_push("e_run_off", 0); sb_push("e_bcd_0", 16'h0000);
    tick(1); pop_check(DONE); pop_check(RUNNING);
    tick(1); pop_check(BCD_OUT);
    sb_push("e_start_ign", 1); sb_push("e_start_bcd", 16'h0000);
    press(KStart); pop_check(DONE); pop_check(BCD_OUT);
    release_keys();
    sb_push("e_clr_bcd", 16'h0003); sb_push("e_clr_done", 0); sb_push("e_clr_run", 0);
    press(KClear); release_keys();
    pop_check(BCD_OUT); pop_check(DONE); pop_check(RUNNING);
    // Zero preset in down mode: start goes straight to DONE.
    PRESET_BCD = 16'h0000;
    tick(2);
    sb_push("e_zero_done", 1); sb_push("e_zero_run", 0);
    press(KStart); pop_check(DONE); pop_check(RUNNING);
    release_keys();
    sb_push("e_zero_clr", 0);
    press(KClear); release_keys(); pop_check(DONE);
    MODE_DOWN = 1'b0;
    tick(2);

    // Asynchronous reset mid-run with a key half-debounced.
    seed_up(16'h0123);
    press(KStart); release_keys();
    press(KLap); release_keys();
    sb_push("f_running", 1); sb_push("f_lap", 1);
    pop_check(RUNNING); pop_check(LAP_ACTIVE);
    snap_pulses = start_pulses + clear_pulses + lap_pulses;
    KEY_START = 1'b0;
    tick(3);
    #3 RESET_N = 1'b0;
    sb_push("f_bcd", 0); sb_push("f_run", 0); sb_push("f_lapa", 0);
    sb_push("f_wrap", 0); sb_push("f_done", 0);
    #1;
    pop_check(BCD_OUT); pop_check(RUNNING); pop_check(LAP_ACTIVE);
    pop_check(WRAP); pop_check(DONE);
    KEY_START = 1'b1;
    tick(2);
    RESET_N = 1'b1;
    sb_push("f_no_pulse", snap_pulses); sb_push("f_idle", 0); sb_push("f_bcd_idle", 0);
    tick(20);
    pop_check(start_pulses + clear_pulses + lap_pulses);
    pop_check(RUNNING); pop_check(BCD_OUT);

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100: count rate in Hz; CLK_HZ/TICK_HZ must be an integer of at least 2.
REQ-003 SHALL have parameter DIGITS, default 8: number of BCD digits, range 1..8.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000: number of stable cycles a key needs before it is accepted.
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port KEY_START, input, 1 bit: raw active-low start/stop key.
REQ-008 SHALL have port KEY_CLEAR, input, 1 bit: raw active-low clear key.
REQ-009 SHALL have port KEY_LAP, input, 1 bit: raw active-low lap key.
REQ-010 SHALL have port MODE_DOWN, input, 1 bit: 0 = count up, 1 = count down.
REQ-011 SHALL have port PRESET_BCD, input, 4*DIGITS bits: start value for down mode.
REQ-012 SHALL have port BCD_OUT, output, 4*DIGITS bits: displayed value; digit 0 is in the LSBs.
REQ-013 SHALL have port RUNNING, output, 1 bit: high while the state is RUN.
REQ-014 SHALL have port LAP_ACTIVE, output, 1 bit: high while the display is frozen.
REQ-015 SHALL have port WRAP, output, 1 bit: one-cycle pulse when the up count rolls over.
REQ-016 SHALL have port DONE, output, 1 bit: high while the state is DONE.

Function
REQ-017 SHALL handle each key in its own debouncer:
- 2-FF synchroniser;
- the accepted level updates only after DEBOUNCE_CYCLES consecutive equal samples;
- a one-cycle press pulse fires on the accepted 1->0 transition;
- a held key produces exactly one pulse.
REQ-018 SHALL produce the press pulse DEBOUNCE_CYCLES+3 rising edges after a clean raw falling edge.
REQ-019 SHALL use states IDLE, RUN, PAUSE and DONE.
REQ-020 SHALL apply start-press transitions:
- IDLE->RUN;
- RUN->PAUSE;
- PAUSE->RUN;
- in DONE the press is ignored;
- IDLE in down mode with an all-zero count goes directly to DONE.
REQ-021 SHALL apply a clear press in IDLE, PAUSE or DONE:
- count <= 0 in up mode, or PRESET_BCD in down mode;
- LAP_ACTIVE <= 0;
- prescaler <= 0;
- state <= IDLE.
REQ-022 SHALL ignore a clear press in RUN.
REQ-023 SHALL give clear priority when clear and start pulse in the same cycle: if the clear acts, the start is discarded; if the clear is ignored (RUN), the start acts.
REQ-024 SHALL latch MODE_DOWN and PRESET_BCD into the count only while IDLE; changes on these inputs in other states have no effect.
REQ-025 SHALL run the prescaler (0..CLK_HZ/TICK_HZ-1) only in RUN, hold it in PAUSE, and issue a tick when it reaches terminal count and wraps to 0.
REQ-026 SHALL apply a tick that coincides with a RUN->PAUSE press, because the state change takes effect on the following cycle.
REQ-027 SHALL, on each tick in up mode, increment the count in BCD with a digit-wise ripple carry (9->0 carries).
REQ-028 SHALL, in up mode, wrap an all-9s count to all-0s, pulse WRAP for one cycle, and remain in RUN.
REQ-029 SHALL, on each tick in down mode, decrement the count in BCD (0->9 borrows); on reaching all-zero the state goes to DONE on the same edge and the count holds at 0.
REQ-030 SHALL toggle LAP_ACTIVE on a lap press in RUN or PAUSE:
- on 0->1, snapshot the count into the lap register;
- the internal count keeps running.
REQ-031 SHALL ignore a lap press in IDLE or DONE.
REQ-032 SHALL drive BCD_OUT from the lap register when LAP_ACTIVE=1, otherwise from the live count, with registered output (one cycle behind the count).
REQ-033 SHALL keep every digit in the range 0..9 at all times.

Reset
REQ-034 SHALL, on RESET_N=0, immediately and asynchronously:
- set state to IDLE;
- clear the count, lap register, prescaler and BCD_OUT to 0;
- drive RUNNING, LAP_ACTIVE, WRAP and DONE low;
- set the debouncer accepted levels to 1 (released) and clear their counters.
REQ-035 SHALL abandon any operation in progress when RESET_N is asserted mid-run, and produce no press pulse after release unless a key is newly debounced low.

Structure
REQ-036 SHALL place the state enum and the BCD digit width constant (4) in the shared package stopwatch_pkg.
REQ-037 SHALL implement the debouncer as sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated three times.

Verification (CLK_HZ=100, TICK_HZ=10, DIGITS=4, DEBOUNCE_CYCLES=4)
REQ-038 SHALL cover: KEY_START held low for 20 cycles -> a single press pulse at edge 7, RUNNING=1, BCD_OUT=0001 after 10 further ticks' worth of cycles (i.e. one tick of 10 cycles).
REQ-039 SHALL cover: up mode, count 9999, one tick -> BCD_OUT=0000, WRAP high for exactly one cycle, RUNNING stays 1.
REQ-040 SHALL cover: down mode, PRESET_BCD=0003, start then 3 ticks -> BCD_OUT=0000, DONE=1; a further start press changes nothing; a clear press -> IDLE with BCD_OUT=0003.
REQ-041 SHALL cover: RUN at 0042, lap press -> BCD_OUT frozen at 0042 while the internal count reaches 0045; second lap press -> BCD_OUT=0045.
REQ-042 SHALL cover: clear and start pulsed in the same cycle while in PAUSE -> IDLE with count 0000; the same pair pulsed while in RUN -> PAUSE with the count unchanged.
REQ-043 SHALL cover: RESET_N pulsed low mid-RUN at 0123 -> all outputs 0 asynchronously, state IDLE, no spurious press pulse after release.
